sprite_renderer: RTL and testbench
==================================

Name: sprite_renderer

Overview:
- Parametrised, pipelined sprite blitter for the 640x480 VGA path; successor to the fixed full-screen sprite stretcher.
- Places one sprite at a per-frame position with power-of-two scaling, optional horizontal mirror, and multi-frame animation.
- Keys out a transparent palette index onto a background colour.
- Drives an external synchronous sprite ROM and a combinational palette. Sits between the game-object logic and the VGA colour output.

Parameters:
- SPRITE_W, 50, sprite width in texels
- SPRITE_H, 40, sprite height in texels
- NUM_FRAMES, 4, animation frames stored back-to-back in ROM
- FRAME_DIV, 6, video frames per animation step (>=1)
- SCALE_LOG2, 1, on-screen scale = 2**SCALE_LOG2 per axis (0..3)
- ADDR_W, 13, ROM address width (>= clog2(SPRITE_W*SPRITE_H*NUM_FRAMES))
- INDEX_W, 8, palette index width
- TRANSPARENT_INDEX, 0, index treated as see-through

Ports:
- vga_clk  in  1  pixel clock, all state on posedge
- reset_n  in  1  asynchronous active-low reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active display region (draw), 0 = blanking (output black)
- frame_start  in  1  one-cycle pulse during vertical blanking
- sprite_x  in  10  requested left edge (screen px)
- sprite_y  in  10  requested top edge
- sprite_en  in  1  requested visibility
- flip_x  in  1  requested horizontal mirror
- anim_restart  in  1  force animation to frame 0
- bg_red, bg_green, bg_blue  in  4 each  background colour for the same pixel (aligned with DrawX/DrawY)
- rom_address  out  ADDR_W  ROM address, registered
- rom_q  in  INDEX_W  ROM data, valid one clock after rom_address
- pal_index  out  INDEX_W  equals rom_q (combinational)
- pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_index (combinational)
- red, green, blue  out  4 each  final colour, registered
- anim_frame  out  clog2(NUM_FRAMES) (min 1)  current animation frame

Behaviour:
- Reset (async, reset_n=0):
  - red/green/blue=0, rom_address=0, anim_frame=0, divider=0.
  - Latched x/y/en/flip=0, so the sprite is invisible until the first frame_start.
  - Pipeline valid/hit/blank flags=0.
- Frame latch: on a frame_start cycle, latch sprite_x/y/en/flip_x into shadow registers. Mid-frame changes to these inputs have no effect until the next frame_start.
- Animation:
  - On frame_start, divider increments. At FRAME_DIV-1 the divider wraps to 0 and anim_frame = (anim_frame+1) mod NUM_FRAMES.
  - anim_restart clears anim_frame and divider on the same edge and has priority over frame_start.
  - NUM_FRAMES=1 holds anim_frame at 0.
- Hit test (stage 0, combinational, using 11-bit unsigned compare, no wrap):
  - hit = en_l && DrawX >= x_l && DrawX < x_l + (SPRITE_W<<SCALE_LOG2) && the same condition in Y.
  - A sprite extending past 639/479 is clipped; columns beyond the screen never alias to column 0.
- Texel coordinates:
  - u = (DrawX-x_l)>>SCALE_LOG2; v = (DrawY-y_l)>>SCALE_LOG2.
  - If flip_l, u' = SPRITE_W-1-u, else u' = u.
- Address: anim_frame*SPRITE_W*SPRITE_H + v*SPRITE_W + u'.
- Pipeline (latency 2 clocks, DrawX/DrawY/blank/bg at edge t produce red/green/blue after edge t+2):
  - Edge t: rom_address <= hit ? addr : 0. Stage-1 regs capture hit, blank, bg.
  - Edge t+1: ROM registers q. Stage-2 regs capture stage-1.
  - Edge t+2 output register:
    - blank2=0 -> 0,0,0
    - else hit2 && rom_q != TRANSPARENT_INDEX -> pal colour
    - else -> bg2
- Simultaneous events: frame_start on the same edge as an active pixel uses the old shadow values for that pixel. Callers pulse only in blanking.
- Reset mid-frame clears the pipeline immediately. The first two output cycles after release are black.

Test Plan:
- Reset, then first frame_start with sprite_x=100, sprite_y=50, en=1. Pixel (100,50) -> rom_address=0 one clock later; output = palette colour two clocks after DrawX presented.
- SCALE_LOG2=1, pixels (101,50),(102,50) -> addresses 0 and 1. Pixel (199,50) hits with u=49; pixel (200,50) misses and outputs bg.
- flip_x=1 latched, pixel (100,50) -> address 49. Pixel (100,51) -> address 49 (v=0); pixel (100,52) -> address 99.
- rom_q=TRANSPARENT_INDEX inside sprite with bg=(3,4,5) -> output (3,4,5). blank=0 on any pixel -> (0,0,0).
- sprite_x=600 (width 100) -> pixels 600..639 hit, then pixel (0,row) misses (no wrap). Change sprite_x mid-frame -> no effect until next frame_start.
- FRAME_DIV=6, NUM_FRAMES=4: 24 frame_starts -> anim_frame sequence 0,1,2,3,0 advancing every 6th pulse; address offset 2000*anim_frame. anim_restart together with frame_start -> anim_frame=0, divider=0.

Source files
------------

// File: rtl/sprite_renderer.sv
// Pipelined single-sprite blitter: frame-latched placement, power-of-two scaling, mirror,
// animation frames from a synchronous ROM, transparent-index keying onto the background.
module sprite_renderer #(
  parameter int SPRITE_W          = 50,
  parameter int SPRITE_H          = 40,
  parameter int NUM_FRAMES        = 4,
  parameter int FRAME_DIV         = 6,
  parameter int SCALE_LOG2        = 1,
  parameter int ADDR_W            = 13,
  parameter int INDEX_W           = 8,
  parameter int TRANSPARENT_INDEX = 0,
  localparam int FRAME_W          = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic               frame_start,
  input  logic [9:0]         sprite_x,
  input  logic [9:0]         sprite_y,
  input  logic               sprite_en,
  input  logic               flip_x,
  input  logic               anim_restart,
  input  logic [3:0]         bg_red,
  input  logic [3:0]         bg_green,
  input  logic [3:0]         bg_blue,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INDEX_W-1:0] rom_q,
  output logic [INDEX_W-1:0] pal_index,
  input  logic [3:0]         pal_red,
  input  logic [3:0]         pal_green,
  input  logic [3:0]         pal_blue,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic [FRAME_W-1:0] anim_frame
);

  localparam int SCALED_W   = SPRITE_W << SCALE_LOG2;
  localparam int SCALED_H   = SPRITE_H << SCALE_LOG2;
  localparam int FRAME_SIZE = SPRITE_W * SPRITE_H;
  localparam int DIV_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [9:0]         x_l_q, x_l_d, y_l_q, y_l_d;
  logic               en_l_q, en_l_d, flip_l_q, flip_l_d;
  logic [FRAME_W-1:0] anim_q, anim_d;
  logic [DIV_W-1:0]   div_q, div_d;

  logic [10:0]        x_end, y_end;
  logic               hit_x, hit_y, hit;
  logic [9:0]         dx, dy, u, v, u_f;
  logic [ADDR_W-1:0]  addr, rom_addr_q, rom_addr_d;

  logic               hit1_q, blank1_q, hit2_q, blank2_q;
  logic [11:0]        bg1_q, bg2_q, rgb_q, rgb_d;

  // Placement and animation state only move on frame_start so a frame never tears.
  always_comb begin
    x_l_d    = x_l_q;
    y_l_d    = y_l_q;
    en_l_d   = en_l_q;
    flip_l_d = flip_l_q;
    anim_d   = anim_q;
    div_d    = div_q;
    if (frame_start) begin
      x_l_d    = sprite_x;
      y_l_d    = sprite_y;
      en_l_d   = sprite_en;
      flip_l_d = flip_x;
    end
    if (anim_restart) begin
      anim_d = '0;
      div_d  = '0;
    end else if (frame_start) begin
      if (div_q == DIV_W'(FRAME_DIV - 1)) begin
        div_d  = '0;
        anim_d = (anim_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : anim_q + FRAME_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // 11-bit compares keep a sprite hanging off the right/bottom edge from wrapping.
  always_comb begin
    x_end = {1'b0, x_l_q} + 11'(SCALED_W);
    y_end = {1'b0, y_l_q} + 11'(SCALED_H);
    hit_x = ({1'b0, DrawX} >= {1'b0, x_l_q}) && ({1'b0, DrawX} < x_end);
    hit_y = ({1'b0, DrawY} >= {1'b0, y_l_q}) && ({1'b0, DrawY} < y_end);
    hit   = en_l_q && hit_x && hit_y;
    dx    = DrawX - x_l_q;
    dy    = DrawY - y_l_q;
    u     = dx >> SCALE_LOG2;
    v     = dy >> SCALE_LOG2;
    u_f   = flip_l_q ? (10'(SPRITE_W - 1) - u) : u;
    addr  = ADDR_W'(anim_q) * ADDR_W'(FRAME_SIZE)
          + ADDR_W'(v) * ADDR_W'(SPRITE_W)
          + ADDR_W'(u_f);
    rom_addr_d = hit ? addr : '0;
  end

  always_comb begin
    rgb_d = bg2_q;
    if (!blank2_q) begin
      rgb_d = '0;
    end else if (hit2_q && (rom_q != INDEX_W'(TRANSPARENT_INDEX))) begin
      rgb_d = {pal_red, pal_green, pal_blue};
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_l_q      <= '0;
      y_l_q      <= '0;
      en_l_q     <= 1'b0;
      flip_l_q   <= 1'b0;
      anim_q     <= '0;
      div_q      <= '0;
      rom_addr_q <= '0;
      hit1_q     <= 1'b0;
      blank1_q   <= 1'b0;
      bg1_q      <= '0;
      hit2_q     <= 1'b0;
      blank2_q   <= 1'b0;
      bg2_q      <= '0;
      rgb_q      <= '0;
    end else begin
      x_l_q      <= x_l_d;
      y_l_q      <= y_l_d;
      en_l_q     <= en_l_d;
      flip_l_q   <= flip_l_d;
      anim_q     <= anim_d;
      div_q      <= div_d;
      rom_addr_q <= rom_addr_d;
      hit1_q     <= hit;
      blank1_q   <= blank;
      bg1_q      <= {bg_red, bg_green, bg_blue};
      hit2_q     <= hit1_q;
      blank2_q   <= blank1_q;
      bg2_q      <= bg1_q;
      rgb_q      <= rgb_d;
    end
  end

  assign rom_address = rom_addr_q;
  assign pal_index   = rom_q;
  assign red         = rgb_q[11:8];
  assign green       = rgb_q[7:4];
  assign blue        = rgb_q[3:0];
  assign anim_frame  = anim_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Self-checking bench for sprite_renderer: ROM/palette models plus a geometric reference model.
module tb_sprite_renderer;

  localparam int SW = 50, SH = 40, NF = 4, FD = 6, SL = 1, AW = 13;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, sprite_x, sprite_y;
  logic        blank, frame_start, sprite_en, flip_x, anim_restart;
  logic [3:0]  bg_red, bg_green, bg_blue;
  logic [AW-1:0] rom_address;
  logic [7:0]  rom_q, pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue, red, green, blue;
  logic [1:0]  anim_frame;

  logic [7:0]  rom_mem [0:(1<<AW)-1];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: latched placement and pulses since the last restart.
  int m_x, m_y, m_pulses;
  bit m_en, m_flip;

  sprite_renderer #(
    .SPRITE_W(SW), .SPRITE_H(SH), .NUM_FRAMES(NF), .FRAME_DIV(FD),
    .SCALE_LOG2(SL), .ADDR_W(AW), .INDEX_W(8), .TRANSPARENT_INDEX(0)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_en(sprite_en), .flip_x(flip_x), .anim_restart(anim_restart),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_address(rom_address), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .anim_frame(anim_frame)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) rom_q <= rom_mem[rom_address];
  assign pal_red   = pal_index[3:0];
  assign pal_green = pal_index[7:4];
  assign pal_blue  = pal_index[3:0] ^ pal_index[7:4];

  function automatic int m_anim();
    return (m_pulses / FD) % NF;
  endfunction

  function automatic bit m_hit(int px, int py);
    int scale = 1 << SL;
    return m_en && px >= m_x && px < m_x + SW * scale && py >= m_y && py < m_y + SH * scale;
  endfunction

  function automatic int m_addr(int px, int py);
    int u, v;
    if (!m_hit(px, py)) return 0;
    u = (px - m_x) / (1 << SL);
    v = (py - m_y) / (1 << SL);
    if (m_flip) u = SW - 1 - u;
    return m_anim() * SW * SH + v * SW + u;
  endfunction

  function automatic logic [11:0] m_rgb(int px, int py, bit bl, logic [11:0] bg);
    logic [7:0] idx;
    if (!bl) return 12'h000;
    if (!m_hit(px, py)) return bg;
    idx = rom_mem[m_addr(px, py)];
    if (idx == 8'd0) return bg;
    return {idx[3:0], idx[7:4], idx[3:0] ^ idx[7:4]};
  endfunction

  task automatic set_px(input int px, input int py, input bit bl, input logic [11:0] bg);
    DrawX = 10'(px);
    DrawY = 10'(py);
    blank = bl;
    {bg_red, bg_green, bg_blue} = bg;
  endtask

  // Drives one isolated pixel and captures its ROM address and final colour.
  task automatic run_pixel(input int px, input int py, input bit bl, input logic [11:0] bg,
                           output logic [AW-1:0] ga, output logic [11:0] gc);
    @(negedge vga_clk);
    set_px(px, py, bl, bg);
    @(posedge vga_clk); #1;
    ga = rom_address;
    @(negedge vga_clk);
    blank = 1'b0;
    @(posedge vga_clk);
    @(posedge vga_clk); #1;
    gc = {red, green, blue};
  endtask

  task automatic frame_pulse(input int x, input int y, input bit en, input bit flip, input bit restart);
    @(negedge vga_clk);
    blank = 1'b0;
    frame_start = 1'b1;
    anim_restart = restart;
    sprite_x = 10'(x);
    sprite_y = 10'(y);
    sprite_en = en;
    flip_x = flip;
    @(posedge vga_clk); #1;
    m_x = x; m_y = y; m_en = en; m_flip = flip;
    if (restart) m_pulses = 0;
    else m_pulses++;
    @(negedge vga_clk);
    frame_start = 1'b0;
    anim_restart = 1'b0;
  endtask

  task automatic test_reset();
    logic [AW-1:0] ga;
    logic [11:0] gc;
    reset_n = 1'b0;
    set_px(100, 50, 1'b1, 12'h123);
    frame_start = 0; anim_restart = 0;
    sprite_x = 10'd100; sprite_y = 10'd50; sprite_en = 1; flip_x = 0;
    m_x = 0; m_y = 0; m_en = 0; m_flip = 0; m_pulses = 0;
    repeat (3) @(posedge vga_clk);
    #1;
    n_checks++;
    if ({red, green, blue} !== 12'h000) $display("FAIL reset_rgb: got %h expected 000", {red, green, blue});
    else n_pass++;
    n_checks++;
    if (rom_address !== '0) $display("FAIL reset_addr: got %0d expected 0", rom_address);
    else n_pass++;
    n_checks++;
    if (anim_frame !== 2'd0) $display("FAIL reset_anim: got %0d expected 0", anim_frame);
    else n_pass++;
    @(negedge vga_clk);
    reset_n = 1'b1;
    // Sprite inputs are requesting (100,50) but nothing is latched yet.
    run_pixel(100, 50, 1'b1, 12'habc, ga, gc);
    n_checks++;
    if (ga !== '0) $display("FAIL prelatch_addr: got %0d expected 0", ga);
    else n_pass++;
    n_checks++;
    if (gc !== 12'habc) $display("FAIL prelatch_rgb: got %h expected abc", gc);
    else n_pass++;
  endtask

  task automatic test_basic();
    int pxs [8] = '{100, 101, 102, 199, 200, 150, 100, 130};
    int pys [8] = '{50, 50, 50, 50, 50, 50, 52, 130};
    int exa [8] = '{0, 0, 1, 49, 0, 25, 50, 0};
    logic [AW-1:0] ga;
    logic [11:0] gc, ec;
    for (int i = 0; i < 2 * SW; i++) if (rom_mem[i] == 8'd0) rom_mem[i] = 8'h11;
    frame_pulse(100, 50, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_pixel(pxs[i], pys[i], 1'b1, 12'h2c7, ga, gc);
      ec = m_rgb(pxs[i], pys[i], 1'b1, 12'h2c7);
      n_checks++;
      if (ga !== AW'(exa[i])) $display("FAIL basic_addr (%0d,%0d): got %0d expected %0d", pxs[i], pys[i], ga, exa[i]);
      else n_pass++;
      n_checks++;
      if (gc !== ec) $display("FAIL basic_rgb (%0d,%0d): got %h expected %h", pxs[i], pys[i], gc, ec);
      else n_pass++;
    end
  endtask

  task automatic test_flip();
    int pxs [4] = '{100, 100, 100, 199};
    int pys [4] = '{50, 51, 52, 50};
    int exa [4] = '{49, 49, 99, 0};
    logic [AW-1:0] ga;
    logic [11:0] gc, ec;
    frame_pulse(100, 50, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_pixel(pxs[i], pys[i], 1'b1, 12'h0f0, ga, gc);
      ec = m_rgb(pxs[i], pys[i], 1'b1, 12'h0f0);
      n_checks++;
      if (ga !== AW'(exa[i])) $display("FAIL flip_addr (%0d,%0d): got %0d expected %0d", pxs[i], pys[i], ga, exa[i]);
      else n_pass++;
      n_checks++;
      if (gc !== ec) $display("FAIL flip_rgb (%0d,%0d): got %h expected %h", pxs[i], pys[i], gc, ec);
      else n_pass++;
    end
  endtask

  task automatic test_transparent();
    logic [AW-1:0] ga;
    logic [11:0] gc;
    frame_pulse(100, 50, 1'b1, 1'b0, 1'b0);
    rom_mem[255] = 8'd0;
    run_pixel(110, 60, 1'b1, 12'h345, ga, gc);
    n_checks++;
    if (gc !== 12'h345) $display("FAIL transparent_rgb: got %h expected 345", gc);
    else n_pass++;
    rom_mem[255] = 8'h9c;
    run_pixel(110, 60, 1'b1, 12'h345, ga, gc);
    n_checks++;
    if (gc !== 12'hc95) $display("FAIL opaque_rgb: got %h expected c95", gc);
    else n_pass++;
    run_pixel(110, 60, 1'b0, 12'h345, ga, gc);
    n_checks++;
    if (gc !== 12'h000) $display("FAIL blank_rgb: got %h expected 000", gc);
    else n_pass++;
  endtask

  task automatic test_clip();
    logic [AW-1:0] ga;
    logic [11:0] gc, ec;
    frame_pulse(600, 100, 1'b1, 1'b0, 1'b0);
    for (int px = 600; px < 640; px++) begin
      run_pixel(px, 100, 1'b1, 12'h777, ga, gc);
      ec = m_rgb(px, 100, 1'b1, 12'h777);
      n_checks++;
      if (ga !== AW'((px - 600) / 2)) $display("FAIL clip_addr px=%0d: got %0d expected %0d", px, ga, (px - 600) / 2);
      else n_pass++;
      n_checks++;
      if (gc !== ec) $display("FAIL clip_rgb px=%0d: got %h expected %h", px, gc, ec);
      else n_pass++;
    end
    run_pixel(0, 100, 1'b1, 12'h777, ga, gc);
    n_checks++;
    if (ga !== '0 || gc !== 12'h777) $display("FAIL clip_nowrap: got addr %0d rgb %h expected 0 777", ga, gc);
    else n_pass++;
    @(negedge vga_clk);
    sprite_x = 10'd0;
    sprite_y = 10'd0;
    run_pixel(620, 100, 1'b1, 12'h777, ga, gc);
    n_checks++;
    if (ga !== AW'(10)) $display("FAIL midframe_hold: got %0d expected 10", ga);
    else n_pass++;
    run_pixel(0, 0, 1'b1, 12'h777, ga, gc);
    n_checks++;
    if (gc !== 12'h777) $display("FAIL midframe_nohit: got %h expected 777", gc);
    else n_pass++;
  endtask

  task automatic test_anim();
    logic [AW-1:0] ga;
    logic [11:0] gc;
    frame_pulse(100, 50, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 33; k++) begin
      frame_pulse(100, 50, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (anim_frame !== 2'(m_anim())) $display("FAIL anim_frame pulse=%0d: got %0d expected %0d", k, anim_frame, m_anim());
      else n_pass++;
      if (k % 3 == 0) begin
        run_pixel(100, 50, 1'b1, 12'h000, ga, gc);
        n_checks++;
        if (ga !== AW'(m_anim() * SW * SH)) $display("FAIL anim_addr pulse=%0d: got %0d expected %0d", k, ga, m_anim() * SW * SH);
        else n_pass++;
      end
    end
    // Restart coinciding with frame_start while mid-way through frame 1.
    frame_pulse(100, 50, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (anim_frame !== 2'd0) $display("FAIL anim_restart: got %0d expected 0", anim_frame);
    else n_pass++;
    for (int k = 1; k <= FD; k++) begin
      frame_pulse(100, 50, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (anim_frame !== 2'(m_anim())) $display("FAIL anim_after_restart pulse=%0d: got %0d expected %0d", k, anim_frame, m_anim());
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int pxs [60], pys [60], exa [60];
    logic [11:0] bgs [60], exc [60];
    bit bls [60];
    int x, y, w, h;
    w = SW << SL;
    h = SH << SL;
    for (int r = 0; r < 4; r++) begin
      x = int'($urandom_range(0, 639));
      y = int'($urandom_range(0, 479));
      frame_pulse(x, y, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'b0);
      for (int i = 0; i < 60; i++) begin
        pxs[i] = x - 10 + int'($urandom_range(0, w + 20));
        pys[i] = y - 10 + int'($urandom_range(0, h + 20));
        if ($urandom_range(0, 5) == 0) pxs[i] = int'($urandom_range(0, 639));
        if (pxs[i] < 0) pxs[i] = 0;
        if (pxs[i] > 639) pxs[i] = 639;
        if (pys[i] < 0) pys[i] = 0;
        if (pys[i] > 479) pys[i] = 479;
        bls[i] = ($urandom_range(0, 9) != 0);
        bgs[i] = 12'($urandom);
        exa[i] = m_addr(pxs[i], pys[i]);
        exc[i] = m_rgb(pxs[i], pys[i], bls[i], bgs[i]);
      end
      for (int i = 0; i < 62; i++) begin
        @(negedge vga_clk);
        if (i < 60) set_px(pxs[i], pys[i], bls[i], bgs[i]);
        else set_px(0, 0, 1'b0, 12'h000);
        @(posedge vga_clk); #1;
        if (i < 60) begin
          n_checks++;
          if (rom_address !== AW'(exa[i])) $display("FAIL stream_addr r=%0d i=%0d (%0d,%0d): got %0d expected %0d", r, i, pxs[i], pys[i], rom_address, exa[i]);
          else n_pass++;
        end
        if (i >= 2) begin
          n_checks++;
          if ({red, green, blue} !== exc[i-2]) $display("FAIL stream_rgb r=%0d i=%0d: got %h expected %h", r, i - 2, {red, green, blue}, exc[i-2]);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    frame_pulse(200, 200, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge vga_clk);
      set_px(200 + i, 210, 1'b1, 12'h5a5);
      @(posedge vga_clk);
    end
    #2 reset_n = 1'b0;
    #1;
    m_x = 0; m_y = 0; m_en = 0; m_flip = 0; m_pulses = 0;
    n_checks++;
    if ({red, green, blue} !== 12'h000 || rom_address !== '0)
      $display("FAIL async_reset: got rgb %h addr %0d expected 000 0", {red, green, blue}, rom_address);
    else n_pass++;
    @(negedge vga_clk);
    reset_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge vga_clk); #1;
      n_checks++;
      if ({red, green, blue} !== ((j < 2) ? 12'h000 : 12'h5a5))
        $display("FAIL post_reset_rgb cycle=%0d: got %h expected %h", j, {red, green, blue}, (j < 2) ? 12'h000 : 12'h5a5);
      else n_pass++;
    end
    n_checks++;
    if (rom_address !== '0 || anim_frame !== 2'd0)
      $display("FAIL post_reset_state: got addr %0d anim %0d expected 0 0", rom_address, anim_frame);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      rom_mem[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) rom_mem[i] = 8'd0;
    end
    test_reset();
    test_basic();
    test_flip();
    test_transparent();
    test_clip();
    test_anim();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
